sdram_arbiter: RTL and testbench
================================

// Module: sdram_arbiter
// PURPOSE
//  Shares the single 32-bit SDRAM access port among NUM_REQ requesters:
//  record writer, playback reader and loop reader.
//  Round-robin arbitration, one transaction in flight at a time.
//  Latches the winner's command and holds it stable until the bus reports
//  completion, then returns read data and a done pulse to the winner.
//  A timeout watchdog stops a hung controller from locking out all requesters.
// PARAMETERS
//  NUM_REQ         3     number of requesters (2..8)
//  TIMEOUT_CYCLES  1024  GRANT cycles allowed before abort (power of 2, >=4)
// PORTS
//  i_clk            in   1            system clock
//  i_rst_n          in   1            async active-low reset
//  req_addr         in   NUM_REQ*23   per-requester word address, slice i = [23*i +: 23]
//  req_read         in   NUM_REQ      level read request, held until done/err
//  req_write        in   NUM_REQ      level write request, held until done/err
//  req_wdata        in   NUM_REQ*32   per-requester write data, slice [32*i +: 32]
//  req_rdata        out  32           read data, shared, valid while req_done
//  req_done         out  NUM_REQ      one-cycle completion pulse to winner
//  req_err          out  NUM_REQ      one-cycle timeout-abort pulse to winner
//  sdram_addr       out  23           to SDRAM bus core
//  sdram_read       out  1            to SDRAM bus core, level
//  sdram_write      out  1            to SDRAM bus core, level
//  sdram_writedata  out  32           to SDRAM bus core
//  sdram_readdata   in   32           from SDRAM bus core
//  sdram_finished   in   1            from SDRAM bus core, one-cycle completion
//  o_grant_id       out  $clog2(NUM_REQ)  current/last winner index
//  o_busy           out  1            state != IDLE
// BEHAVIOUR
//  Reset values:
//   - all outputs 0
//   - state=IDLE, last_grant=NUM_REQ-1 (so requester 0 has first priority)
//   - timeout counter 0
//  IDLE:
//   - requester i is pending if req_read[i]|req_write[i].
//   - Search starts at last_grant+1 mod NUM_REQ; first pending index wins.
//   - On the edge: latch addr, wdata and op.
//     - op=WRITE if req_write[i], else READ (write wins when both are set).
//   - On the edge: grant=i, last_grant=i, cnt=0, go to GRANT.
//  GRANT:
//   - sdram_read/sdram_write driven from latched op only; addr/wdata from latches.
//   - Command is visible on the cycle after the request is first seen
//     (1-cycle arbitration latency).
//   - cnt increments each cycle.
//   - sdram_finished=1: capture sdram_readdata into rdata_q (write op: rdata_q=0),
//     go to RESP with ok.
//   - Else cnt==TIMEOUT_CYCLES-1: go to RESP with err, rdata_q=0.
//  RESP (exactly 1 cycle):
//   - sdram_read=sdram_write=0, so the SDRAM core is back in IDLE.
//   - req_done[grant] = ok, or req_err[grant] = err.
//   - req_rdata = rdata_q.
//   - Next state IDLE.
//  Requester rules:
//   - The requester must drop its request on the edge ending its done/err cycle.
//   - A request still high in the following IDLE is treated as a new transaction.
//  Request withdrawn during GRANT:
//   - Latched command still runs to finished/timeout; the RESP pulse is still issued.
//   - The requester ignores it.
//  Other requests during GRANT/RESP:
//   - Ignored, never dropped; re-evaluated in the next IDLE.
//  Fairness:
//   - With all requesters pending, grants rotate 0,1,2,0... with no repeat
//     while others wait.
//  sdram_finished outside GRANT: ignored.
//  Reset mid-transaction:
//   - Commands deassert immediately (async); no done/err is issued.
//  Widths:
//   - cnt is $clog2(TIMEOUT_CYCLES) bits, no wrap.
//   - grant index arithmetic is mod NUM_REQ (explicit compare, not power-of-2 wrap).
// STRUCTURE
//  sdram_arb_pkg:
//   - typedef enum logic [1:0] {IDLE, GRANT, RESP} arb_state_t
//   - typedef enum logic {OP_READ, OP_WRITE} sdram_op_t
//   - localparam SDRAM_AW=23, SDRAM_DW=32
//  Sub-module sdram_rr_picker (combinational):
//   - in: pending[NUM_REQ], last_grant
//   - out: valid, winner index
//  Top: FSM, command latches, timeout counter, response mux.
// TESTING
//  1. Single read, req 1 addr 0x000123, bus finishes 3 cycles after command
//     with 0xDEADBEEF
//     -> sdram_read high 3 cycles, then req_done[1] for 1 cycle
//        with req_rdata=0xDEADBEEF, o_grant_id=1.
//  2. All 3 request writes continuously, each finished after 1 cycle
//     -> grant order 0,1,2,0,1,2 and each sdram_writedata matches its requester.
//  3. req_read and req_write both high on req 0
//     -> sdram_write=1, sdram_read=0 for the whole GRANT.
//  4. sdram_finished never asserted, TIMEOUT_CYCLES=8
//     -> req_err[winner] pulses on cycle 9 after grant, req_rdata=0, back to IDLE.
//  5. Req 2 drops its read 1 cycle into GRANT
//     -> sdram_read stays high until finished, req_done[2] still pulses,
//        and req 0 pending is served next.
//  6. i_rst_n low mid-GRANT
//     -> sdram_read/write=0 asynchronously, no done/err, and after release
//        requester 0 wins first.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM port arbiter.
package sdram_arb_pkg;

  localparam int SDRAM_AW = 23;
  localparam int SDRAM_DW = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } sdram_op_t;

  // Fold an index that may exceed the requester count by less than one lap.
  function automatic int unsigned rr_wrap(input int unsigned idx, input int unsigned n);
    if (idx >= n) begin
      return idx - n;
    end else begin
      return idx;
    end
  endfunction

endpackage

// File: rtl/sdram_rr_picker.sv
// Combinational round-robin picker: first pending requester after last_grant.
module sdram_rr_picker
  import sdram_arb_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0]         pending,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic                       valid,
  output logic [$clog2(NUM_REQ)-1:0] winner
);

  localparam int IW = $clog2(NUM_REQ);

  logic [2*NUM_REQ-1:0] pend2_s;
  logic [2*NUM_REQ-1:0] rot_s;
  int unsigned          base_s;

  // Rotate the doubled pending vector so bit 0 is the highest-priority slot,
  // then take the lowest set bit and map it back to a requester index.
  always_comb begin
    base_s  = 32'(last_grant) + 32'd1;
    pend2_s = {pending, pending};
    rot_s   = pend2_s >> base_s;
    valid   = 1'b0;
    winner  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!valid && rot_s[k]) begin
        valid  = 1'b1;
        winner = IW'(rr_wrap(base_s + 32'(k), 32'(NUM_REQ)));
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM access port between NUM_REQ
// requesters, one transaction in flight, with a timeout watchdog.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_REQ*SDRAM_AW-1:0]   req_addr,
  input  logic [NUM_REQ-1:0]            req_read,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*SDRAM_DW-1:0]   req_wdata,
  output logic [SDRAM_DW-1:0]           req_rdata,
  output logic [NUM_REQ-1:0]            req_done,
  output logic [NUM_REQ-1:0]            req_err,
  output logic [SDRAM_AW-1:0]           sdram_addr,
  output logic                          sdram_read,
  output logic                          sdram_write,
  output logic [SDRAM_DW-1:0]           sdram_writedata,
  input  logic [SDRAM_DW-1:0]           sdram_readdata,
  input  logic                          sdram_finished,
  output logic [$clog2(NUM_REQ)-1:0]    o_grant_id,
  output logic                          o_busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX   = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] LAST_INIT = IW'(NUM_REQ - 1);

  arb_state_t          state_r;
  arb_state_t          state_nxt_s;
  logic [IW-1:0]       last_grant_r;
  logic [IW-1:0]       grant_r;
  sdram_op_t           op_r;
  sdram_op_t           op_nxt_s;
  logic [SDRAM_AW-1:0] addr_r;
  logic [SDRAM_DW-1:0] wdata_r;
  logic [CW-1:0]       cnt_r;
  logic                rd_r;
  logic                wr_r;
  logic [SDRAM_DW-1:0] rdata_r;
  logic [NUM_REQ-1:0]  done_r;
  logic [NUM_REQ-1:0]  err_r;

  logic [NUM_REQ-1:0]  pending_s;
  logic                pick_valid_s;
  logic [IW-1:0]       pick_idx_s;
  logic                load_s;
  logic                fin_ok_s;
  logic                fin_err_s;
  logic [NUM_REQ-1:0]  grant_onehot_s;

  logic [SDRAM_AW-1:0] addr_a  [NUM_REQ];
  logic [SDRAM_DW-1:0] wdata_a [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_a[g]  = req_addr[g*SDRAM_AW +: SDRAM_AW];
    assign wdata_a[g] = req_wdata[g*SDRAM_DW +: SDRAM_DW];
  end

  assign pending_s      = req_read | req_write;
  assign grant_onehot_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_r;
  assign op_nxt_s       = req_write[pick_idx_s] ? OP_WRITE : OP_READ;

  sdram_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .pending    (pending_s),
    .last_grant (last_grant_r),
    .valid      (pick_valid_s),
    .winner     (pick_idx_s)
  );

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode plus the one-cycle strobes that steer the datapath.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    fin_ok_s    = 1'b0;
    fin_err_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_valid_s) begin
          state_nxt_s = GRANT;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GRANT: begin
        // Completion beats the watchdog when both land on the same cycle.
        if (sdram_finished) begin
          state_nxt_s = RESP;
          fin_ok_s    = 1'b1;
        end else if (cnt_r == CNT_MAX) begin
          state_nxt_s = RESP;
          fin_err_s   = 1'b1;
        end else begin
          state_nxt_s = GRANT;
        end
      end
      RESP: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Command latches: capture the winner's request and hold it through GRANT.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      grant_r      <= '0;
      last_grant_r <= LAST_INIT;
      op_r         <= OP_READ;
      addr_r       <= '0;
      wdata_r      <= '0;
      rd_r         <= 1'b0;
      wr_r         <= 1'b0;
    end else if (load_s) begin
      grant_r      <= pick_idx_s;
      last_grant_r <= pick_idx_s;
      op_r         <= op_nxt_s;
      addr_r       <= addr_a[pick_idx_s];
      wdata_r      <= wdata_a[pick_idx_s];
      rd_r         <= (op_nxt_s == OP_READ);
      wr_r         <= (op_nxt_s == OP_WRITE);
    end else if (fin_ok_s || fin_err_s) begin
      rd_r         <= 1'b0;
      wr_r         <= 1'b0;
    end else begin
      rd_r         <= rd_r;
      wr_r         <= wr_r;
    end
  end

  // Watchdog counter: cycles spent in GRANT, parked at its limit rather than wrapping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_r <= '0;
    end else if (load_s) begin
      cnt_r <= '0;
    end else if ((state_r == GRANT) && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Response registers: valid only during the single RESP cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      done_r  <= '0;
      err_r   <= '0;
      rdata_r <= '0;
    end else if (fin_ok_s) begin
      done_r  <= grant_onehot_s;
      err_r   <= '0;
      rdata_r <= (op_r == OP_READ) ? sdram_readdata : '0;
    end else if (fin_err_s) begin
      done_r  <= '0;
      err_r   <= grant_onehot_s;
      rdata_r <= '0;
    end else begin
      done_r  <= '0;
      err_r   <= '0;
      rdata_r <= '0;
    end
  end

  assign sdram_addr      = addr_r;
  assign sdram_writedata = wdata_r;
  assign sdram_read      = rd_r;
  assign sdram_write     = wr_r;
  assign req_rdata       = rdata_r;
  assign req_done        = done_r;
  assign req_err         = err_r;
  assign o_grant_id      = grant_r;
  assign o_busy          = (state_r != IDLE);

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: transaction-level reference model,
// per-cycle compare, directed scenarios and randomized traffic.
module tb_sdram_arbiter;

  localparam int N = 3;
  localparam int T = 8;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic [68:0]   req_addr;
  logic [2:0]    req_read = 3'b000;
  logic [2:0]    req_write = 3'b000;
  logic [95:0]   req_wdata;
  logic [31:0]   req_rdata;
  logic [2:0]    req_done;
  logic [2:0]    req_err;
  logic [22:0]   sdram_addr;
  logic          sdram_read;
  logic          sdram_write;
  logic [31:0]   sdram_writedata;
  logic [31:0]   sdram_readdata = 32'd0;
  logic          sdram_finished = 1'b0;
  logic [1:0]    o_grant_id;
  logic          o_busy;

  logic [22:0]   a_addr  [N];
  logic [31:0]   a_wdata [N];
  assign req_addr  = {a_addr[2], a_addr[1], a_addr[0]};
  assign req_wdata = {a_wdata[2], a_wdata[1], a_wdata[0]};

  sdram_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .req_addr(req_addr), .req_read(req_read), .req_write(req_write),
    .req_wdata(req_wdata), .req_rdata(req_rdata), .req_done(req_done),
    .req_err(req_err), .sdram_addr(sdram_addr), .sdram_read(sdram_read),
    .sdram_write(sdram_write), .sdram_writedata(sdram_writedata),
    .sdram_readdata(sdram_readdata), .sdram_finished(sdram_finished),
    .o_grant_id(o_grant_id), .o_busy(o_busy)
  );

  initial forever #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one transaction in flight, described by phase
  // (0 idle, 1 on bus, 2 reporting), owner, op, latched fields and age.
  int          m_state = 0;
  int          m_last  = N - 1;
  int          m_owner = 0;
  int          m_age   = 0;
  int          m_ok    = 0;
  int          m_wr    = 0;
  logic [22:0] m_addr  = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_rdata = '0;

  initial forever begin
    @(posedge i_clk or negedge i_rst_n);
    if (!i_rst_n) begin
      m_state = 0; m_last = N - 1; m_owner = 0; m_age = 0;
      m_ok = 0; m_wr = 0; m_addr = '0; m_wdata = '0; m_rdata = '0;
    end else if (m_state == 0) begin
      int w;
      logic [2:0] pend;
      pend = req_read | req_write;
      w = -1;
      for (int k = 1; k <= N; k++) begin
        if (w < 0 && pend[(m_last + k) % N]) w = (m_last + k) % N;
      end
      if (w >= 0) begin
        m_owner = w; m_last = w; m_age = 0; m_state = 1;
        m_wr = req_write[w] ? 1 : 0;
        m_addr = a_addr[w]; m_wdata = a_wdata[w];
      end
    end else if (m_state == 1) begin
      if (sdram_finished) begin
        m_ok = 1; m_rdata = m_wr ? 32'd0 : sdram_readdata; m_state = 2;
      end else if (m_age == T - 1) begin
        m_ok = 0; m_rdata = 32'd0; m_state = 2;
      end else begin
        m_age = m_age + 1;
      end
    end else begin
      m_state = 0;
    end
  end

  // Per-cycle compare of every output against the model.
  initial forever begin
    @(negedge i_clk);
    chk("sdram_read",  sdram_read,  (m_state == 1 && m_wr == 0));
    chk("sdram_write", sdram_write, (m_state == 1 && m_wr == 1));
    chk("req_done",    req_done,    (m_state == 2 && m_ok == 1) ? (32'd1 << m_owner) : 32'd0);
    chk("req_err",     req_err,     (m_state == 2 && m_ok == 0) ? (32'd1 << m_owner) : 32'd0);
    chk("req_rdata",   req_rdata,   (m_state == 2) ? m_rdata : 32'd0);
    chk("o_grant_id",  o_grant_id,  m_owner);
    chk("o_busy",      o_busy,      (m_state != 0));
    if (m_state == 1) begin
      chk("sdram_addr",  sdram_addr,      m_addr);
      chk("sdram_wdata", sdram_writedata, m_wdata);
    end
  end

  // SDRAM core stand-in: completes after bus_lat command cycles (0 = never).
  int          bus_lat  = 0;
  int          bus_rand = 0;
  int          bus_spur = 0;
  logic [31:0] bus_data = 32'hDEADBEEF;

  initial forever begin
    @(negedge i_clk);
    sdram_readdata = $urandom;
    sdram_finished = 1'b0;
    if (m_state == 1) begin
      if (bus_rand != 0 && m_age == 0) bus_lat = $urandom_range(1, 10);
      if (bus_lat > 0 && m_age == bus_lat - 1) begin
        sdram_finished = 1'b1;
        if (bus_rand == 0) sdram_readdata = bus_data;
      end
    end else if (bus_spur != 0 && $urandom_range(0, 3) == 0) begin
      sdram_finished = 1'b1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Advance one cycle; the reporting requester drops its request.
  task automatic step();
    @(negedge i_clk);
    #1;
    if (m_state == 2) begin
      req_read  = req_read  & ~(3'd1 << m_owner);
      req_write = req_write & ~(3'd1 << m_owner);
    end
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    req_read = 3'b000;
    req_write = 3'b000;
    bus_rand = 0;
    bus_spur = 0;
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  int          rd_cyc, wr_cyc, cyc, got, seen;
  int          order[$];
  int          exp_order[6] = '{0, 1, 2, 0, 1, 2};
  logic [2:0]  msk;

  initial begin
    for (int i = 0; i < N; i++) begin
      a_addr[i] = '0;
      a_wdata[i] = '0;
    end
    repeat (2) @(negedge i_clk);
    #1;
    chk("reset_busy", o_busy, 1'b0);
    chk("reset_done", req_done, 3'b000);
    chk("reset_cmd", {sdram_read, sdram_write}, 2'b00);

    // Single read from requester 1, bus finishes on the 3rd command cycle.
    do_reset();
    bus_lat = 3; bus_data = 32'hDEADBEEF;
    a_addr[1] = 23'h000123;
    req_read = 3'b010;
    rd_cyc = 0; got = 0;
    for (int c = 0; c < 30 && got == 0; c++) begin
      step();
      if (c == 0) chk("t1_latency", sdram_read, 1'b1);
      if (sdram_read) begin
        rd_cyc++;
        chk("t1_addr", sdram_addr, 23'h000123);
      end
      if (req_done != 3'b000) begin
        got = 1;
        chk("t1_done", req_done, 3'b010);
        chk("t1_rdata", req_rdata, 32'hDEADBEEF);
        chk("t1_grant", o_grant_id, 2'd1);
      end
    end
    chk("t1_seen", got, 1);
    chk("t1_read_cycles", rd_cyc, 3);

    // All three write continuously, one-cycle completions: strict rotation.
    do_reset();
    bus_lat = 1;
    for (int i = 0; i < N; i++) a_wdata[i] = 32'hA000_0000 + 32'(i);
    req_write = 3'b111;
    order.delete();
    for (int c = 0; c < 80 && order.size() < 6; c++) begin
      step();
      if (sdram_write) begin
        order.push_back(int'(o_grant_id));
        chk("t2_wdata", sdram_writedata, 32'hA000_0000 + 32'(o_grant_id));
      end
      for (int i = 0; i < N; i++) begin
        if (!(m_state == 2 && m_owner == i)) req_write = req_write | (3'd1 << i);
      end
    end
    chk("t2_count", order.size(), 6);
    for (int i = 0; i < 6 && i < order.size(); i++) chk("t2_order", order[i], exp_order[i]);
    req_write = 3'b000;

    // Read and write both requested: write wins for the whole command.
    do_reset();
    bus_lat = 2;
    req_read = 3'b001; req_write = 3'b001;
    rd_cyc = 0; wr_cyc = 0; got = 0;
    for (int c = 0; c < 30 && got == 0; c++) begin
      step();
      if (sdram_read) rd_cyc++;
      if (sdram_write) wr_cyc++;
      if (req_done != 3'b000) begin
        got = 1;
        chk("t3_done", req_done, 3'b001);
        chk("t3_rdata", req_rdata, 32'd0);
      end
    end
    chk("t3_seen", got, 1);
    chk("t3_write_cycles", wr_cyc, 2);
    chk("t3_read_cycles", rd_cyc, 0);

    // Bus never finishes: error pulse on the 9th busy cycle.
    do_reset();
    bus_lat = 0;
    req_write = 3'b010;
    cyc = 0; got = 0;
    for (int c = 0; c < 40 && got == 0; c++) begin
      step();
      if (o_busy) cyc++;
      if (req_err != 3'b000) begin
        got = 1;
        chk("t4_err", req_err, 3'b010);
        chk("t4_cycle", cyc, 9);
        chk("t4_rdata", req_rdata, 32'd0);
        chk("t4_done", req_done, 3'b000);
      end
    end
    chk("t4_seen", got, 1);
    step();
    chk("t4_idle", o_busy, 1'b0);

    // Requester 2 withdraws after one command cycle; requester 0 goes next.
    do_reset();
    bus_lat = 4;
    req_read = 3'b100;
    rd_cyc = 0; got = 0; seen = 0;
    for (int c = 0; c < 40 && got == 0; c++) begin
      step();
      if (sdram_read) rd_cyc++;
      if (o_busy && seen == 0) begin
        seen = 1;
        req_read = 3'b001;
      end
      if (req_done != 3'b000) begin
        got = 1;
        chk("t5_done", req_done, 3'b100);
      end
    end
    chk("t5_seen", got, 1);
    chk("t5_read_cycles", rd_cyc, 4);
    got = 0;
    for (int c = 0; c < 10 && got == 0; c++) begin
      step();
      if (sdram_read) begin
        got = 1;
        chk("t5_next_grant", o_grant_id, 2'd0);
      end
    end
    chk("t5_next_seen", got, 1);

    // Asynchronous reset in the middle of a command.
    do_reset();
    bus_lat = 0;
    req_read = 3'b010;
    got = 0;
    for (int c = 0; c < 10 && got == 0; c++) begin
      step();
      if (sdram_read) got = 1;
    end
    chk("t6_started", got, 1);
    step();
    #1;
    i_rst_n = 1'b0;
    #1;
    chk("t6_async_read", sdram_read, 1'b0);
    chk("t6_async_busy", o_busy, 1'b0);
    req_read = 3'b111;
    for (int c = 0; c < 2; c++) begin
      step();
      chk("t6_no_resp", {req_done, req_err}, 6'd0);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    got = 0;
    for (int c = 0; c < 10 && got == 0; c++) begin
      step();
      if (o_busy) begin
        got = 1;
        chk("t6_first_grant", o_grant_id, 2'd0);
      end
    end
    chk("t6_seen", got, 1);

    // Randomized traffic with random latencies, timeouts, withdrawals and stray completions.
    do_reset();
    bus_rand = 1;
    bus_spur = 1;
    for (int c = 0; c < 4000; c++) begin
      step();
      for (int i = 0; i < N; i++) begin
        msk = 3'd1 << i;
        if (((req_read | req_write) & msk) == 3'b000) begin
          if (!(m_state == 2 && m_owner == i) && $urandom_range(0, 3) == 0) begin
            int kind;
            a_addr[i]  = 23'($urandom);
            a_wdata[i] = $urandom;
            kind = $urandom_range(0, 2);
            if (kind != 1) req_read  = req_read  | msk;
            if (kind != 0) req_write = req_write | msk;
          end
        end else if (m_state == 1 && m_owner == i && $urandom_range(0, 15) == 0) begin
          req_read  = req_read  & ~msk;
          req_write = req_write & ~msk;
        end
      end
    end
    req_read = 3'b000;
    req_write = 3'b000;
    bus_spur = 0;
    repeat (20) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
